wm8978_i2s_rx: RTL and testbench



---
 rtl/wm8978_i2s_rx_pkg.sv | 18 +
 rtl/wm8978_i2s_rx_sync_edge.sv | 32 +++
 rtl/wm8978_i2s_rx.sv | 163 ++++++++++++++++
 tb/tb_wm8978_i2s_rx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/wm8978_i2s_rx_pkg.sv
// Shared types and constants for the WM8978 ADC I2S receiver.
package wm8978_i2s_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LEFT,
    CAPTURE
  } state_t;

  // Largest supported word length; sizes the bit counter.
  localparam int WL_MAX = 31;
  localparam int CNT_W  = $clog2(WL_MAX + 1);

  // Channel encoding follows the LRC level: low = left, high = right.
  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/wm8978_i2s_rx_sync_edge.sv
// Synchroniser for one asynchronous codec line, plus a history flop that
// turns the synced level into a single-clk rising-edge pulse.
module i2s_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Shift the raw input through the synchroniser chain and keep one cycle of history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample its
      // predecessor's pre-edge value, which is what forms the chain.
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~hist_q;

endmodule

// File: rtl/wm8978_i2s_rx.sv
// WM8978 ADC I2S receiver: oversamples BCLK/LRC/ADCDAT in the clk domain,
// reassembles MSB-first words and emits coherent left/right pairs.
module wm8978_i2s_rx
  import wm8978_i2s_rx_pkg::*;
#(
  parameter int WL          = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_done,
  input  logic          aud_bclk,
  input  logic          aud_lrc,
  input  logic          aud_adcdat,
  output logic [WL-1:0] left_data,
  output logic [WL-1:0] right_data,
  output logic          data_valid,
  output logic          frame_err
);

  localparam logic [CNT_W-1:0] WL_CNT  = CNT_W'(WL);
  localparam logic [CNT_W-1:0] WL_LAST = CNT_W'(WL - 1);

  logic bclk_rise, lrc_s, dat_s;
  logic bclk_level_unused, lrc_rise_unused, dat_rise_unused;

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
    .clk(clk), .rst_n(rst_n), .din(aud_bclk),
    .level(bclk_level_unused), .rise(bclk_rise)
  );

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrc (
    .clk(clk), .rst_n(rst_n), .din(aud_lrc),
    .level(lrc_s), .rise(lrc_rise_unused)
  );

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dat (
    .clk(clk), .rst_n(rst_n), .din(aud_adcdat),
    .level(dat_s), .rise(dat_rise_unused)
  );

  state_t           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [WL-1:0]    shift_q, left_stage_q, shift_next;
  logic             lrc_last_q, ch_q, left_ok_q, pend_q;

  logic lrc_chg, start_left, half_chg, half_err, shift_en, word_done;

  // An LRC change only counts when observed at a BCLK rise.
  assign lrc_chg    = bclk_rise && (lrc_s != lrc_last_q);
  assign shift_next = {shift_q[WL-2:0], dat_s};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; losing cfg_done always forces IDLE.
  always_comb begin
    state_d = state_q;
    if (!cfg_done) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      state_d = WAIT_LEFT;
        WAIT_LEFT: if (start_left) state_d = CAPTURE;
        CAPTURE:   state_d = CAPTURE;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Per-state control strobes that drive the capture datapath.
  always_comb begin
    // NOTE: every combinational output gets a default up front so no path
    // through the case leaves it unassigned and a latch is never inferred.
    start_left = 1'b0;
    half_chg   = 1'b0;
    half_err   = 1'b0;
    shift_en   = 1'b0;
    word_done  = 1'b0;
    case (state_q)
      WAIT_LEFT: start_left = lrc_chg && (lrc_s == CH_LEFT);
      CAPTURE: begin
        half_chg  = lrc_chg;
        half_err  = lrc_chg && (bit_cnt_q < WL_CNT);
        shift_en  = bclk_rise && !lrc_chg && (bit_cnt_q < WL_CNT);
        word_done = shift_en && (bit_cnt_q == WL_LAST);
      end
      default: ;
    endcase
  end

  // Capture datapath: shifting, staging the left word and publishing pairs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the shift and staging registers are reset as well, so the
      // outputs and any later pair are deterministic from power-up.
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      left_stage_q <= '0;
      lrc_last_q   <= 1'b0;
      ch_q         <= CH_LEFT;
      left_ok_q    <= 1'b0;
      pend_q       <= 1'b0;
      left_data    <= '0;
      right_data   <= '0;
      data_valid   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (bclk_rise) lrc_last_q <= lrc_s;

      if (!cfg_done) begin
        // Abandon everything in flight silently; published outputs hold.
        bit_cnt_q <= '0;
        shift_q   <= '0;
        left_ok_q <= 1'b0;
        pend_q    <= 1'b0;
      end else begin
        if (start_left) begin
          bit_cnt_q <= '0;
          shift_q   <= '0;
          ch_q      <= CH_LEFT;
        end

        // A completed right word is published one clk after its last bit.
        if (pend_q) begin
          left_data  <= left_stage_q;
          right_data <= shift_q;
          data_valid <= 1'b1;
          left_ok_q  <= 1'b0;
          pend_q     <= 1'b0;
        end

        if (half_chg) begin
          // New half-frame: this rise carries the old word's trailing bit.
          if (half_err) begin
            frame_err <= 1'b1;
            left_ok_q <= 1'b0;
          end
          bit_cnt_q <= '0;
          shift_q   <= '0;
          ch_q      <= lrc_s;
        end else if (shift_en) begin
          shift_q   <= shift_next;
          bit_cnt_q <= bit_cnt_q + CNT_W'(1);
          if (word_done) begin
            if (ch_q == CH_LEFT) begin
              left_stage_q <= shift_next;
              left_ok_q    <= 1'b1;
            end else if (ch_q == CH_RIGHT && left_ok_q) begin
              pend_q <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wm8978_i2s_rx.sv
// Directed bench for wm8978_i2s_rx: a behavioural codec drives 64fs I2S
// frames and the bench checks pairing, errors, latency and enable/reset.
module tb_wm8978_i2s_rx;

  localparam int WL          = 24;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 8;                // clk cycles per BCLK phase
  localparam int LAT         = SYNC_STAGES + 2;  // BCLK rise -> data_valid
  localparam int ACT_NONE    = 0;
  localparam int ACT_EN      = 1;
  localparam int ACT_DIS     = 2;
  localparam int ACT_RST     = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_done = 1'b0;
  logic          aud_bclk = 1'b1;
  logic          aud_lrc = 1'b1;
  logic          aud_adcdat = 1'b0;
  logic [WL-1:0] left_data, right_data;
  logic          data_valid, frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_both = 0;
  int n_unstable = 0;
  logic [WL-1:0] prev_l = '0;
  logic [WL-1:0] prev_r = '0;

  wm8978_i2s_rx #(.WL(WL), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_done(cfg_done),
    .aud_bclk(aud_bclk),
    .aud_lrc(aud_lrc),
    .aud_adcdat(aud_adcdat),
    .left_data(left_data),
    .right_data(right_data),
    .data_valid(data_valid),
    .frame_err(frame_err)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pulse bookkeeping, latency and output stability, sampled mid-cycle.
  always @(negedge clk) begin
    if (data_valid) begin
      n_valid++;
      check("latency", 32'(cyc - rise_cyc), 32'(LAT));
    end
    if (frame_err) n_err++;
    if (data_valid && frame_err) n_both++;
    if (rst_n && !data_valid && (left_data !== prev_l || right_data !== prev_r))
      n_unstable++;
    prev_l = left_data;
    prev_r = right_data;
  end

  task automatic do_act(input int act);
    case (act)
      ACT_EN:  cfg_done = 1'b1;
      ACT_DIS: cfg_done = 1'b0;
      ACT_RST: begin
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_left", 32'(left_data), 32'h0);
        check("rst_right", 32'(right_data), 32'h0);
        #2 rst_n = 1'b1;
      end
      default: ;
    endcase
  endtask

  // One half-frame of nbclk BCLK periods; LRC and data change on the fall.
  task automatic send_half(input logic ch, input logic [WL-1:0] word, input int nbclk,
                           input logic pad, input int act_at, input int act);
    for (int i = 0; i < nbclk; i++) begin
      repeat (HALF) @(negedge clk);
      #2;
      aud_bclk = 1'b0;
      if (i == 0) aud_lrc = ch;
      if (i >= 1 && i <= WL) aud_adcdat = word[WL-i];
      else                   aud_adcdat = pad;
      if (i == act_at) do_act(act);
      repeat (HALF) @(negedge clk);
      #2;
      aud_bclk = 1'b1;
      if (ch && i == WL) rise_cyc = cyc;
    end
  endtask

  task automatic send_frame(input logic [WL-1:0] l, input logic [WL-1:0] r, input logic pad);
    send_half(1'b0, l, 32, pad, -1, ACT_NONE);
    send_half(1'b1, r, 32, pad, -1, ACT_NONE);
  endtask

  initial begin
    int v0;
    int e0;

    repeat (3) @(negedge clk);
    check("reset_left", 32'(left_data), 32'h0);
    check("reset_right", 32'(right_data), 32'h0);
    check("reset_valid", 32'(data_valid), 32'h0);
    check("reset_err", 32'(frame_err), 32'h0);
    #2 rst_n = 1'b1;

    // Configuration not done: frames must be ignored entirely.
    repeat (3) send_frame(24'h123456, 24'hABCDEF, 1'b0);
    check("idle_valid", 32'(n_valid), 32'd0);
    check("idle_err", 32'(n_err), 32'd0);
    check("idle_left", 32'(left_data), 32'h0);
    check("idle_right", 32'(right_data), 32'h0);

    // Enable in mid right half: that right word is dropped.
    send_half(1'b0, 24'h123456, 32, 1'b0, -1, ACT_NONE);
    send_half(1'b1, 24'hABCDEF, 32, 1'b0, 10, ACT_EN);
    check("midenable_valid", 32'(n_valid), 32'd0);
    send_frame(24'h123456, 24'hABCDEF, 1'b0);
    check("first_pair_valid", 32'(n_valid), 32'd1);
    check("first_pair_left", 32'(left_data), 32'h123456);
    check("first_pair_right", 32'(right_data), 32'hABCDEF);
    send_frame(24'h123456, 24'hABCDEF, 1'b0);
    check("second_pair_valid", 32'(n_valid), 32'd2);
    check("good_frames_err", 32'(n_err), 32'd0);

    // Truncated left half-frame: one error, no pair, then recovery.
    v0 = n_valid;
    e0 = n_err;
    send_half(1'b0, 24'h123456, 20, 1'b0, -1, ACT_NONE);
    send_half(1'b1, 24'hABCDEF, 32, 1'b0, -1, ACT_NONE);
    check("trunc_err", 32'(n_err - e0), 32'd1);
    check("trunc_valid", 32'(n_valid - v0), 32'd0);
    check("trunc_hold_left", 32'(left_data), 32'h123456);
    send_frame(24'h654321, 24'h13579B, 1'b0);
    check("recover_valid", 32'(n_valid - v0), 32'd1);
    check("recover_left", 32'(left_data), 32'h654321);
    check("recover_right", 32'(right_data), 32'h13579B);
    check("recover_err", 32'(n_err - e0), 32'd1);

    // Negative extremes with padding bits of 1.
    v0 = n_valid;
    send_frame(24'h800000, 24'hFFFFFF, 1'b1);
    check("neg_valid", 32'(n_valid - v0), 32'd1);
    check("neg_left", 32'(left_data), 32'h800000);
    check("neg_right", 32'(right_data), 32'hFFFFFF);

    // cfg_done dropped mid right word: silent abort, outputs hold.
    v0 = n_valid;
    e0 = n_err;
    send_half(1'b0, 24'h0A0B0C, 32, 1'b0, -1, ACT_NONE);
    send_half(1'b1, 24'h112233, 32, 1'b0, 10, ACT_DIS);
    check("drop_valid", 32'(n_valid - v0), 32'd0);
    check("drop_err", 32'(n_err - e0), 32'd0);
    check("drop_hold_left", 32'(left_data), 32'h800000);
    check("drop_hold_right", 32'(right_data), 32'hFFFFFF);
    cfg_done = 1'b1;
    send_frame(24'h0A0B0C, 24'h112233, 1'b0);
    check("reenable_valid", 32'(n_valid - v0), 32'd1);
    check("reenable_left", 32'(left_data), 32'h0A0B0C);
    check("reenable_right", 32'(right_data), 32'h112233);

    // Reset mid right word: outputs clear, capture restarts cleanly.
    v0 = n_valid;
    e0 = n_err;
    send_half(1'b0, 24'h123456, 32, 1'b0, -1, ACT_NONE);
    send_half(1'b1, 24'hABCDEF, 32, 1'b0, 10, ACT_RST);
    check("rstmid_valid", 32'(n_valid - v0), 32'd0);
    check("rstmid_err", 32'(n_err - e0), 32'd0);
    check("rstmid_left", 32'(left_data), 32'h0);
    check("rstmid_right", 32'(right_data), 32'h0);
    send_frame(24'h7FFFFF, 24'h000001, 1'b0);
    check("post_rst_valid", 32'(n_valid - v0), 32'd1);
    check("post_rst_left", 32'(left_data), 32'h7FFFFF);
    check("post_rst_right", 32'(right_data), 32'h000001);

    check("valid_and_err_together", 32'(n_both), 32'd0);
    check("outputs_stable", 32'(n_unstable), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
